// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus transaction engine.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_WD,
    A_SETUP,
    A_PULSE,
    A_HOLD,
    D_SETUP,
    D_PULSE,
    D_HOLD,
    GAP
  } state_t;

  localparam int unsigned DEF_T_SETUP = 2;
  localparam int unsigned DEF_T_PULSE = 4;
  localparam int unsigned DEF_T_HOLD  = 2;
  localparam int unsigned DEF_T_GAP   = 4;

  localparam logic STROBE_IDLE = 1'b1;
  localparam logic STROBE_ACT  = 1'b0;

  // Counter width able to hold m-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Loadable down-counter timing one bus phase; last is high when the count reaches zero.
module rtc_bus_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned MAX_T = 4,
  localparam int unsigned CW = cnt_w(MAX_T)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          last
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)               count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - CW'(1);
  end

  assign last = (count == '0);

endmodule

// File: rtl/rtc_bus_engine.sv
// Single/burst read-write engine for the multiplexed RTC bus.
// Optional BCD checker on read data: define RTC_BUS_BCD_CHECK_EN.
module rtc_bus_engine
  import rtc_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_PULSE = DEF_T_PULSE,
  parameter int unsigned T_HOLD  = DEF_T_HOLD,
  parameter int unsigned T_GAP   = DEF_T_GAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              busy,
  output logic              bcd_err,
  output logic              reg_a_d,
  output logic              reg_cs,
  output logic              reg_rd,
  output logic              reg_wr,
  inout  wire  [DATA_W-1:0] dato
);

  localparam int unsigned T_MAX =
    (T_SETUP > T_PULSE ? T_SETUP : T_PULSE) > (T_HOLD > T_GAP ? T_HOLD : T_GAP) ?
    (T_SETUP > T_PULSE ? T_SETUP : T_PULSE) : (T_HOLD > T_GAP ? T_HOLD : T_GAP);
  localparam int unsigned CW = cnt_w(T_MAX);

  state_t            state, state_next;
  logic              write_q;
  logic [DATA_W-1:0] addr_q, wdata_q, bus_out;
  logic [LEN_W-1:0]  beats_q;
  logic              accept, sample, drive, tload, tlast, last_beat;
  logic [CW-1:0]     tval;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_ready  = (state == WAIT_WD) && wr_valid;
  assign sample    = (state == D_PULSE) && tlast && !write_q;
  assign last_beat = (beats_q == LEN_W'(1));

  rtc_bus_phase_timer #(.MAX_T(T_MAX)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tload),
    .load_val (tval),
    .last     (tlast)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && cmd_len != '0) state_next = cmd_write ? WAIT_WD : A_SETUP;
      WAIT_WD: if (wr_valid) state_next = A_SETUP;
      A_SETUP: if (tlast) state_next = A_PULSE;
      A_PULSE: if (tlast) state_next = A_HOLD;
      A_HOLD:  if (tlast) state_next = D_SETUP;
      D_SETUP: if (tlast) state_next = D_PULSE;
      D_PULSE: if (tlast) state_next = D_HOLD;
      D_HOLD:  if (tlast) state_next = GAP;
      GAP:     if (tlast) state_next = last_beat ? IDLE : (write_q ? WAIT_WD : A_SETUP);
      default: state_next = IDLE;
    endcase
  end

  // Every phase entry is a state change, so the timer reloads on any transition.
  always_comb begin
    tload = (state_next != state);
    case (state_next)
      A_SETUP, D_SETUP: tval = CW'(T_SETUP - 1);
      A_PULSE, D_PULSE: tval = CW'(T_PULSE - 1);
      A_HOLD,  D_HOLD:  tval = CW'(T_HOLD - 1);
      GAP:              tval = CW'(T_GAP - 1);
      default:          tval = '0;
    endcase
  end

  always_comb begin
    reg_cs  = STROBE_IDLE;
    reg_rd  = STROBE_IDLE;
    reg_wr  = STROBE_IDLE;
    reg_a_d = 1'b1;
    drive   = 1'b0;
    bus_out = addr_q;
    case (state)
      A_SETUP, A_HOLD: begin
        reg_cs = STROBE_ACT; reg_a_d = 1'b0; drive = 1'b1;
      end
      A_PULSE: begin
        reg_cs = STROBE_ACT; reg_a_d = 1'b0; drive = 1'b1; reg_wr = STROBE_ACT;
      end
      D_SETUP, D_HOLD: begin
        reg_cs = STROBE_ACT; drive = write_q; bus_out = wdata_q;
      end
      D_PULSE: begin
        reg_cs = STROBE_ACT; drive = write_q; bus_out = wdata_q;
        if (write_q) reg_wr = STROBE_ACT;
        else         reg_rd = STROBE_ACT;
      end
      default: ;
    endcase
  end

  assign dato = drive ? bus_out : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      beats_q  <= '0;
    end else begin
      state    <= state_next;
      done     <= (accept && cmd_len == '0) || (state == GAP && tlast && last_beat);
      rd_valid <= sample;
      if (sample) rd_data <= dato;
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        beats_q <= cmd_len;
      end
      if (wr_ready) wdata_q <= wr_data;
      if (state == GAP && tlast) begin
        beats_q <= beats_q - LEN_W'(1);
        addr_q  <= addr_q + DATA_W'(1);
      end
    end
  end

`ifdef RTC_BUS_BCD_CHECK_EN
  logic bcd_bad, bcd_q;

  always_comb begin
    bcd_bad = 1'b0;
    for (int unsigned i = 0; i < DATA_W / 4; i++)
      if (dato[i*4 +: 4] > 4'd9) bcd_bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || accept)      bcd_q <= 1'b0;
    else if (sample && bcd_bad) bcd_q <= 1'b1;
  end

  assign bcd_err = bcd_q;
`else
  assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_engine.sv
// Directed self-checking bench for rtc_bus_engine with a simple RTC bus model.
module tb_rtc_bus_engine;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_write, wr_valid;
  logic [7:0] cmd_addr, wr_data, rtc_val;
  logic [3:0] cmd_len;
  logic       cmd_ready, wr_ready, rd_valid, done, busy, bcd_err;
  logic       reg_a_d, reg_cs, reg_rd, reg_wr;
  logic [7:0] rd_data;
  wire  [7:0] dato;

  always #5 clk = ~clk;

  // RTC model drives only while its read strobe is low; pullups show a released bus as 0xFF.
  assign dato = (!reg_rd) ? rtc_val : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (dato[i]);
  end

  rtc_bus_engine #(
    .DATA_W(8), .LEN_W(4), .T_SETUP(2), .T_PULSE(4), .T_HOLD(2), .T_GAP(4)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy),
    .bcd_err(bcd_err), .reg_a_d(reg_a_d), .reg_cs(reg_cs), .reg_rd(reg_rd),
    .reg_wr(reg_wr), .dato(dato)
  );

  // Bus monitor
  int unsigned cyc = 0, n_addr = 0, n_wdat = 0, n_rv = 0, n_done = 0, n_wrr = 0;
  int unsigned n_cs = 0, n_apulse = 0, n_rdlow = 0, acc_cyc = 0, done_cyc = 0;
  logic [7:0]  addr_log [64], wdat_log [64], rv_log [64];
  logic        prev_awr = 1'b1, prev_dwr = 1'b1;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_awr <= reg_wr | reg_a_d;
    prev_dwr <= reg_wr | !reg_a_d;
    if (!reg_cs) n_cs <= n_cs + 1;
    if (!reg_rd) n_rdlow <= n_rdlow + 1;
    if (!reg_wr && !reg_a_d) begin
      n_apulse <= n_apulse + 1;
      if (prev_awr) begin addr_log[n_addr[5:0]] <= dato; n_addr <= n_addr + 1; end
    end
    if (!reg_wr && reg_a_d && prev_dwr) begin
      wdat_log[n_wdat[5:0]] <= dato; n_wdat <= n_wdat + 1;
    end
    if (rd_valid) begin rv_log[n_rv[5:0]] <= rd_data; n_rv <= n_rv + 1; end
    if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
    if (wr_ready) n_wrr <= n_wrr + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
  end

  int unsigned n_chk = 0, n_pass = 0, stall_bad = 0;
  int unsigned b_addr, b_wdat, b_rv, b_done, b_wrr, b_cs, b_apulse, b_rdlow;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap();
    b_addr = n_addr; b_wdat = n_wdat; b_rv = n_rv; b_done = n_done;
    b_wrr = n_wrr; b_cs = n_cs; b_apulse = n_apulse; b_rdlow = n_rdlow;
  endtask

  task automatic settle(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [7:0] a, input logic [3:0] l);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    @(negedge clk);
    while (!done && n < 400) begin @(negedge clk); n++; end
    check(tag, 32'(n < 400), 1);
  endtask

  task automatic write_cmd(input logic [7:0] a, input logic [3:0] l,
                           input logic [7:0] d [4], input int unsigned stall);
    int unsigned n;
    wr_data = d[0]; wr_valid = 1'b1;
    send(1'b1, a, l);
    for (int unsigned b = 0; b < 32'(l); b++) begin
      n = 0;
      while (n < 100) begin @(negedge clk); if (wr_ready) break; n++; end
      check("wr_handshake", 32'(n < 100), 1);
      @(posedge clk); #1;
      if (b + 1 < 32'(l)) begin
        if (stall != 0) begin
          wr_valid = 1'b0;
          for (int unsigned k = 1; k <= stall + 20; k++) begin
            @(negedge clk);
            if (k > 20 && (!reg_cs || dato !== 8'hFF)) stall_bad++;
          end
          @(posedge clk); #1;
        end
        wr_data = d[b+1]; wr_valid = 1'b1;
      end else begin
        wr_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int unsigned n, eps;
    logic prev;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rtc_val = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_strobes", {reg_cs, reg_rd, reg_wr, reg_a_d}, 4'hF);
    check("rst_bus", dato, 8'hFF);
    check("rst_flags", {done, rd_valid, wr_ready, bcd_err}, 4'h0);
    check("rst_rd_data", rd_data, 8'h00);
    @(posedge clk); #1 reset = 1'b0;

    // Single read
    rtc_val = 8'h59; snap();
    send(1'b0, 8'h21, 4'd1);
    wait_done("rd1_done_seen");
    settle(6);
    check("rd1_addr", addr_log[b_addr[5:0]], 8'h21);
    check("rd1_addr_cnt", n_addr - b_addr, 1);
    check("rd1_apulse", n_apulse - b_apulse, 4);
    check("rd1_rdlow", n_rdlow - b_rdlow, 4);
    check("rd1_rv_cnt", n_rv - b_rv, 1);
    check("rd1_rv_data", rv_log[b_rv[5:0]], 8'h59);
    check("rd1_rd_data", rd_data, 8'h59);
    check("rd1_latency", done_cyc - acc_cyc, 21);
    check("rd1_done_cnt", n_done - b_done, 1);
    check("rd1_cs_cycles", n_cs - b_cs, 16);
    check("rd1_bcd", bcd_err, 0);

    // Burst write, data ready immediately
    snap();
    write_cmd(8'h21, 4'd3, '{8'h10, 8'h20, 8'h30, 8'h00}, 0);
    wait_done("bw_done_seen");
    settle(6);
    check("bw_addr0", addr_log[b_addr[5:0]], 8'h21);
    check("bw_addr1", addr_log[6'(b_addr + 1)], 8'h22);
    check("bw_addr2", addr_log[6'(b_addr + 2)], 8'h23);
    check("bw_data0", wdat_log[b_wdat[5:0]], 8'h10);
    check("bw_data1", wdat_log[6'(b_wdat + 1)], 8'h20);
    check("bw_data2", wdat_log[6'(b_wdat + 2)], 8'h30);
    check("bw_wr_ready_cnt", n_wrr - b_wrr, 3);
    check("bw_done_cnt", n_done - b_done, 1);
    check("bw_rdlow", n_rdlow - b_rdlow, 0);

    // Address wrap with write-data stall before beat 2
    snap(); stall_bad = 0;
    write_cmd(8'hFF, 4'd2, '{8'hA5, 8'h5A, 8'h00, 8'h00}, 10);
    wait_done("wrap_done_seen");
    settle(6);
    check("wrap_addr0", addr_log[b_addr[5:0]], 8'hFF);
    check("wrap_addr1", addr_log[6'(b_addr + 1)], 8'h00);
    check("wrap_data1", wdat_log[6'(b_wdat + 1)], 8'h5A);
    check("wrap_stall_idle", stall_bad, 0);
    check("wrap_done_cnt", n_done - b_done, 1);

    // Reset during D_PULSE of beat 2 of a read burst
    rtc_val = 8'h11;
    send(1'b0, 8'h40, 4'd3);
    n = 0; eps = 0; prev = 1'b1;
    while (eps < 2 && n < 200) begin
      @(negedge clk);
      if (!reg_rd && prev) eps++;
      prev = reg_rd; n++;
    end
    check("rst_mid_reach", eps, 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rst_mid_strobes", {reg_cs, reg_rd, reg_wr, reg_a_d}, 4'hF);
    check("rst_mid_bus", dato, 8'hFF);
    check("rst_mid_ready", {cmd_ready, busy}, 2'b10);
    check("rst_mid_rd_data", rd_data, 8'h00);
    snap();
    settle(40);
    check("rst_mid_no_done", n_done - b_done, 0);
    check("rst_mid_no_cs", n_cs - b_cs, 0);

    // Zero-length command
    snap();
    send(1'b0, 8'h33, 4'd0);
    @(negedge clk);
    check("len0_done", done, 1);
    settle(10);
    check("len0_no_cs", n_cs - b_cs, 0);
    check("len0_done_cnt", n_done - b_done, 1);

    // Non-BCD read data
    rtc_val = 8'h3A;
    send(1'b0, 8'h05, 4'd1);
    wait_done("bcd_done_seen");
    settle(2);
    check("bcd_rd_data", rd_data, 8'h3A);
`ifdef RTC_BUS_BCD_CHECK_EN
    check("bcd_set", bcd_err, 1);
    settle(10);
    check("bcd_sticky", bcd_err, 1);
    rtc_val = 8'h12;
    send(1'b0, 8'h06, 4'd1);
    @(negedge clk);
    check("bcd_clear", bcd_err, 0);
    wait_done("bcd2_done_seen");
    settle(2);
    check("bcd_ok_read", bcd_err, 0);
`else
    check("bcd_off", bcd_err, 0);
    settle(10);
    check("bcd_off_hold", bcd_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rtc_bus_engine.md
Name: rtc_bus_engine

Overview:
Parametrised transaction engine for a multiplexed address/data parallel RTC bus with active-low `a_d`, `cs`, `rd` and `wr` strobes and a bidirectional `dato`. It accepts single or burst read/write commands from the clock-controller core and sequences address and data phases with programmable phase timing. Each burst beat auto-increments the register address. It replaces hand-coded bus strobing in the digital-clock controller and sits between the controller FSM and the RTC pins.

Parameters:
- DATA_W, default 8: width of the bus, address and data.
- LEN_W, default 4: width of the burst-length field; a burst is 1..2^LEN_W-1 beats.
- T_SETUP, default 2: cycles the bus is driven before the strobe asserts (≥1).
- T_PULSE, default 4: cycles the `rd`/`wr` strobe is low (≥1).
- T_HOLD, default 2: cycles after the strobe deasserts, with `cs` still low (≥1).
- T_GAP, default 4: idle cycles between beats and after the last beat (≥1).

Ports:
- clk  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  DATA_W  first RTC register address.
- cmd_len  in  LEN_W  beat count.
- wr_data  in  DATA_W  write beat data.
- wr_valid  in  1  write data available.
- wr_ready  out  1  one-cycle pulse; wr_data consumed.
- rd_data  out  DATA_W  read beat data.
- rd_valid  out  1  one-cycle pulse per read beat; no backpressure.
- done  out  1  one-cycle pulse when the command completes.
- busy  out  1  high whenever the engine is not in IDLE.
- bcd_err  out  1  BCD error flag; see Optional Feature.
- reg_a_d  out  1  0 = address phase, 1 = data phase.
- reg_cs  out  1  chip select, active low.
- reg_rd  out  1  read strobe, active low.
- reg_wr  out  1  write strobe, active low.
- dato  inout  DATA_W  RTC bus; driven only when the engine owns it, else Z.

Behaviour:
- Reset, synchronous and active-high:
  - FSM goes to IDLE.
  - reg_cs, reg_rd, reg_wr and reg_a_d = 1.
  - dato = Z.
  - cmd_ready = 1; busy, done, rd_valid, wr_ready and bcd_err = 0; rd_data = 0.
  - Reset mid-transaction aborts the command; the bus is idle on the next cycle and there is no done pulse.
- States: IDLE, WAIT_WD, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, GAP.
  - A single down-counter times each phase.
  - A beat counter and an address register are loaded at accept.
- IDLE: on accept, latch write/addr/len.
  - len = 0 is treated as a no-op: done pulses the next cycle and no bus activity occurs.
  - Otherwise go to WAIT_WD for a write, or A_SETUP for a read.
- WAIT_WD (write only):
  - Bus idle; wait for wr_valid.
  - When wr_valid = 1, pulse wr_ready, latch wr_data and go to A_SETUP.
  - A stall here holds the bus idle indefinitely.
- Address phase: reg_a_d = 0, reg_cs = 0, dato = addr in A_SETUP, A_PULSE and A_HOLD.
  - reg_wr = 0 only during A_PULSE; this is the address latch strobe.
  - Phase lengths are T_SETUP, T_PULSE and T_HOLD.
- Data phase: reg_a_d = 1, reg_cs = 0.
  - Write: dato = latched data through D_SETUP, D_PULSE and D_HOLD; reg_wr = 0 in D_PULSE.
  - Read: dato = Z; reg_rd = 0 in D_PULSE.
  - Read sampling: dato is registered on the last D_PULSE cycle. rd_valid pulses on the first D_HOLD cycle with rd_data stable until the next beat.
- GAP: all strobes = 1, dato = Z, for T_GAP cycles. Then:
  - Beats remain: addr += 1 (wraps modulo 2^DATA_W) and go to WAIT_WD or A_SETUP.
  - Otherwise: go to IDLE and pulse done on the first IDLE cycle, together with cmd_ready = 1.
- Beat timing: one beat is 2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP cycles. With defaults that is 20, plus 1 WAIT_WD cycle for writes.
- Bus-fight rule: in a read, dato is released in the same cycle reg_a_d rises; the engine never drives while reg_rd = 0.
- Command inputs are ignored while busy.

Optional Feature:
- Macro: RTC_BUS_BCD_CHECK_EN.
- Defined: every read beat checks both nibbles of rd_data. If any nibble > 9, bcd_err is set (sticky) in the rd_valid cycle; it clears on reset or on the next accepted command.
- Undefined: bcd_err is tied to 0 and the checker logic is absent.

Decomposition:
- Package rtc_bus_pkg holds:
  - the state enum;
  - localparam phase lengths;
  - the active-low idle constants for the strobes.
- Sub-module rtc_bus_phase_timer: loadable down-counter with a `last` flag, sized with $clog2 of the largest T_* parameter.

Test Plan:
- Single read: addr = 0x21, len = 1, model drives 0x59 → A_PULSE reg_wr low 4 cycles with dato = 0x21; D_PULSE reg_rd low 4 cycles; rd_valid with 0x59; done 21 cycles after accept.
- Burst write: addr = 0x21, len = 3, data 0x10/0x20/0x30 supplied immediately → three beats at addresses 0x21, 0x22, 0x23 carrying those data; 3 wr_ready pulses; exactly one done.
- Wrap and stall: addr = 0xFF, len = 2 write; wr_valid withheld 10 cycles before beat 2 → second address is 0x00; bus idle (cs = 1, dato = Z) throughout the stall.
- Reset mid-burst: reset asserted during D_PULSE of beat 2 → next cycle all strobes 1, dato Z, cmd_ready = 1; no done pulse.
- len = 0 command → done on the next cycle; reg_cs never low.
- RTC_BUS_BCD_CHECK_EN defined, read returns 0x3A → bcd_err = 1 and sticky; next command clears it. Macro undefined: bcd_err stays 0.
